// File: rtl/trace_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_buffer_pkg                                                           |
// | Shared scope constants and capture FSM state encoding.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package trace_buffer_pkg;

  localparam int SCOPE_DATA_W = 12;
  localparam int SCOPE_ADDR_W = 10;
  localparam int H_VISIBLE    = 640;
  localparam int V_VISIBLE    = 480;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/trace_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_bank_ram                                                             |
// | Simple dual-port RAM: one write port, one registered read port.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module trace_bank_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 640
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr[IDX_W-1:0]];
  end

endmodule
`default_nettype wire

// File: rtl/trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_buffer                                                               |
// | Rising-edge triggered sample capture into a frame-synchronous ping-pong.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int DATA_W       = SCOPE_DATA_W,
  parameter int DEPTH        = H_VISIBLE,
  parameter int ADDR_W       = SCOPE_ADDR_W,
  parameter int TRIG_LEVEL   = 2048,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] pixel_x,
  output logic [DATA_W-1:0] value,
  output logic              armed,
  output logic              capture_done,
  output logic              front_valid
);

  localparam int                CNT_W       = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_FIRST_NXT = (DEPTH == 1) ? '0 : ADDR_W'(1);
  localparam logic [DATA_W-1:0] c_TRIG      = DATA_W'(TRIG_LEVEL);
  localparam logic [CNT_W-1:0]  c_AUTO_LAST = CNT_W'((AUTO_TIMEOUT > 0) ? AUTO_TIMEOUT - 1 : 0);

  cap_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt, w_waddr, w_raddr;
  logic [CNT_W-1:0]  r_auto_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_prev_sample;
  logic              r_prev_ok, r_bank_sel, r_front_valid, r_rd_ok, r_rd_sel;
  logic              w_trig, w_auto, w_fire, w_we, w_swap;
  logic [1:0]        w_bank_we;
  logic [DATA_W-1:0] w_rdata [2];

  assign w_trig = r_prev_ok && (r_prev_sample < c_TRIG) && (sample_in >= c_TRIG);
  assign w_auto = (AUTO_TIMEOUT != 0) && (r_auto_cnt == c_AUTO_LAST);
  assign w_fire = w_trig || w_auto;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_we          = 1'b0;
    w_waddr       = r_wr_addr;
    w_wr_addr_nxt = r_wr_addr;
    w_cnt_nxt     = r_auto_cnt;
    w_swap        = 1'b0;
    case (r_state)
      ARMED: begin
        if (sample_valid) begin
          if (w_fire) begin
            w_we          = 1'b1;
            w_waddr       = '0;
            w_wr_addr_nxt = c_FIRST_NXT;
            w_cnt_nxt     = '0;
            w_state_nxt   = (DEPTH == 1) ? DONE : CAPTURE;
          end else if (r_auto_cnt != '1) begin
            w_cnt_nxt = r_auto_cnt + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          w_we = 1'b1;
          if (r_wr_addr == c_LAST) begin
            w_wr_addr_nxt = '0;
            w_state_nxt   = DONE;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 1'b1;
          end
        end
      end
      DONE: begin
        if (frame_start) begin
          w_swap      = 1'b1;
          w_state_nxt = ARMED;
        end
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_addr     <= '0;
      r_auto_cnt    <= '0;
      r_prev_sample <= '0;
      r_prev_ok     <= 1'b0;
      r_bank_sel    <= 1'b0;
      r_front_valid <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_rd_sel      <= 1'b0;
    end else begin
      r_wr_addr  <= w_wr_addr_nxt;
      r_auto_cnt <= w_cnt_nxt;
      if (sample_valid) begin
        r_prev_sample <= sample_in;
      end
      // A swap restarts edge detection so the new capture needs a fresh below-level sample.
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_front_valid <= 1'b1;
        r_prev_ok     <= 1'b0;
      end else if (sample_valid) begin
        r_prev_ok <= 1'b1;
      end
      r_rd_ok  <= r_front_valid && ({1'b0, pixel_x} < c_DEPTH);
      r_rd_sel <= r_bank_sel;
    end
  end

  // bank_sel=0: bank0 is front, bank1 is back.
  assign w_bank_we[0] = w_we & r_bank_sel;
  assign w_bank_we[1] = w_we & ~r_bank_sel;
  assign w_raddr      = ({1'b0, pixel_x} < c_DEPTH) ? pixel_x : '0;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      trace_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_ram (
        .clk     (clk),
        .i_we    (w_bank_we[b]),
        .i_waddr (w_waddr),
        .i_wdata (sample_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata[b])
      );
    end
  endgenerate

  assign value        = r_rd_ok ? w_rdata[r_rd_sel] : '0;
  assign armed        = (r_state == ARMED);
  assign capture_done = (r_state == DONE);
  assign front_valid  = r_front_valid;

endmodule
`default_nettype wire
